// File: rtl/survivor_mem_ctrl.sv
// survivor_mem_ctrl
// Packs ACS survivor decisions into RAM words, writes them page by page
// into a single-port synchronous RAM, and shares that RAM with a
// traceback reader through an alternating write/read arbiter.
//
// Optional feature: define SMC_COLLISION_CHECK_EN to enable the sticky
// page-collision flag. Without it, collision is tied low.

module survivor_mem_ctrl #(
  parameter int N_ACS       = 4,
  parameter int WD_RAM_DATA = 8,
  parameter int WD_DEPTH    = 4,
  parameter int WD_SEG      = 3
) (
  input  logic                         CLOCK,
  input  logic                         Reset,
  input  logic                         Active,
  input  logic                         Init,
  input  logic [N_ACS-1:0]             Survivors,
  input  logic                         surv_valid,
  output logic                         surv_ready,
  output logic [WD_DEPTH-1:0]          acs_page,
  input  logic                         tb_req,
  input  logic [WD_SEG-1:0]            tb_seg,
  output logic                         tb_ready,
  input  logic                         tb_step,
  output logic [WD_DEPTH-1:0]          tb_page,
  output logic                         tb_valid,
  output logic [WD_RAM_DATA-1:0]       tb_data,
  output logic                         ram_en,
  output logic                         ram_we,
  output logic [WD_DEPTH+WD_SEG-1:0]   ram_addr,
  output logic [WD_RAM_DATA-1:0]       ram_wdata,
  input  logic [WD_RAM_DATA-1:0]       ram_rdata,
  output logic                         collision
);

  // Beats per RAM word and the width of the lane counter that walks them.
  localparam int R      = WD_RAM_DATA / N_ACS;
  localparam int LANE_W = (R > 1) ? $clog2(R) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(R - 1);
  localparam logic [WD_SEG-1:0] LAST_SEG  = {WD_SEG{1'b1}};

  // Which kind of access won the most recent write/read contention.
  typedef enum logic {
    ARB_LAST_READ  = 1'b0,
    ARB_LAST_WRITE = 1'b1
  } arb_e;

  logic [LANE_W-1:0]      lane_q, lane_d;
  logic [WD_RAM_DATA-1:0] pack_q, pack_d;
  logic [WD_RAM_DATA-1:0] hold_q, hold_d;
  logic                   wr_pend_q, wr_pend_d;
  logic [WD_SEG-1:0]      wr_seg_q, wr_seg_d;
  logic [WD_DEPTH-1:0]    acs_page_q, acs_page_d;
  logic [WD_DEPTH-1:0]    tb_page_q, tb_page_d;
  arb_e                   arb_q, arb_d;
  logic                   rd_pend_q, rd_pend_d;
  logic                   tb_valid_q, tb_valid_d;
  logic [WD_RAM_DATA-1:0] tb_data_q, tb_data_d;

  logic                   accept;
  logic                   wr_grant;
  logic                   rd_grant;
  logic                   contention;
  logic [WD_RAM_DATA-1:0] merged;

  // Survivor handshake: stall only when the last lane would overwrite an
  // unwritten held word.
  always_comb begin
    surv_ready = Active && !(wr_pend_q && (lane_q == LAST_LANE));
    accept     = surv_valid && surv_ready;
  end

  // Arbitration: a lone requester wins; on contention the kind that lost
  // last time wins. No RAM access is started while Reset is asserted.
  always_comb begin
    contention = wr_pend_q && tb_req;
    wr_grant   = !Reset && wr_pend_q && (!tb_req || (arb_q == ARB_LAST_READ));
    rd_grant   = !Reset && tb_req && !(wr_pend_q && (arb_q == ARB_LAST_READ));
  end

  // RAM port drive; all fields forced to zero when idle.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (wr_grant) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = {acs_page_q, wr_seg_q};
      ram_wdata = hold_q;
    end else if (rd_grant) begin
      ram_en    = 1'b1;
      ram_addr  = {tb_page_q, tb_seg};
    end
  end

  // Current packer content with the incoming beat dropped into its lane.
  always_comb begin
    merged = pack_q;
    merged[lane_q*N_ACS +: N_ACS] = Survivors;
  end

  // Packer, holding register and write addressing next state.
  always_comb begin
    lane_d     = lane_q;
    pack_d     = pack_q;
    hold_d     = hold_q;
    wr_pend_d  = wr_pend_q;
    wr_seg_d   = wr_seg_q;
    acs_page_d = acs_page_q;
    if (wr_grant) begin
      wr_pend_d = 1'b0;
      wr_seg_d  = wr_seg_q + 1'b1;
      if (wr_seg_q == LAST_SEG) begin
        acs_page_d = acs_page_q + 1'b1;
      end
    end
    if (accept) begin
      pack_d = merged;
      if (lane_q == LAST_LANE) begin
        hold_d    = merged;
        wr_pend_d = 1'b1;
        lane_d    = '0;
      end else begin
        lane_d = lane_q + 1'b1;
      end
    end
  end

  // Traceback page, arbitration history and read return pipeline.
  always_comb begin
    tb_page_d  = tb_page_q;
    arb_d      = arb_q;
    rd_pend_d  = rd_grant;
    tb_valid_d = rd_pend_q;
    tb_data_d  = tb_data_q;
    if (Init) begin
      tb_page_d = acs_page_q - 1'b1;
    end else if (tb_step) begin
      tb_page_d = tb_page_q - 1'b1;
    end
    if (contention && !Reset) begin
      arb_d = wr_grant ? ARB_LAST_WRITE : ARB_LAST_READ;
    end
    if (rd_pend_q) begin
      tb_data_d = ram_rdata;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      lane_q     <= '0;
      pack_q     <= '0;
      hold_q     <= '0;
      wr_pend_q  <= 1'b0;
      wr_seg_q   <= '0;
      acs_page_q <= '0;
      tb_page_q  <= '0;
      arb_q      <= ARB_LAST_READ;
      rd_pend_q  <= 1'b0;
      tb_valid_q <= 1'b0;
      tb_data_q  <= '0;
    end else begin
      lane_q     <= lane_d;
      pack_q     <= pack_d;
      hold_q     <= hold_d;
      wr_pend_q  <= wr_pend_d;
      wr_seg_q   <= wr_seg_d;
      acs_page_q <= acs_page_d;
      tb_page_q  <= tb_page_d;
      arb_q      <= arb_d;
      rd_pend_q  <= rd_pend_d;
      tb_valid_q <= tb_valid_d;
      tb_data_q  <= tb_data_d;
    end
  end

  assign acs_page = acs_page_q;
  assign tb_page  = tb_page_q;
  assign tb_ready = rd_grant;
  assign tb_valid = tb_valid_q;
  assign tb_data  = tb_data_q;

`ifdef SMC_COLLISION_CHECK_EN
  logic collision_q, collision_d;

  // Sticky flag: traceback read touching the page currently being written.
  always_comb begin
    collision_d = collision_q;
    if (Init) begin
      collision_d = 1'b0;
    end else if (rd_grant && (tb_page_q == acs_page_q)) begin
      collision_d = 1'b1;
    end
  end

  // Collision flag register.
  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      collision_q <= 1'b0;
    end else begin
      collision_q <= collision_d;
    end
  end

  assign collision = collision_q;
`else
  assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_survivor_mem_ctrl.sv
// tb_survivor_mem_ctrl
// Randomised bench for survivor_mem_ctrl with a transaction-level
// reference model (word queue, write counter, reference memory image,
// read return queue) and a behavioural single-port RAM.

module tb_survivor_mem_ctrl;

  localparam int N_ACS       = 4;
  localparam int WD_RAM_DATA = 8;
  localparam int WD_DEPTH    = 4;
  localparam int WD_SEG      = 3;
  localparam int R           = WD_RAM_DATA / N_ACS;
  localparam int SEGS        = 1 << WD_SEG;
  localparam int PAGES       = 1 << WD_DEPTH;
  localparam int WORDS       = SEGS * PAGES;

  logic                       CLOCK = 1'b0;
  logic                       Reset;
  logic                       Active;
  logic                       Init;
  logic [N_ACS-1:0]           Survivors;
  logic                       surv_valid;
  logic                       surv_ready;
  logic [WD_DEPTH-1:0]        acs_page;
  logic                       tb_req;
  logic [WD_SEG-1:0]          tb_seg;
  logic                       tb_ready;
  logic                       tb_step;
  logic [WD_DEPTH-1:0]        tb_page;
  logic                       tb_valid;
  logic [WD_RAM_DATA-1:0]     tb_data;
  logic                       ram_en;
  logic                       ram_we;
  logic [WD_DEPTH+WD_SEG-1:0] ram_addr;
  logic [WD_RAM_DATA-1:0]     ram_wdata;
  logic [WD_RAM_DATA-1:0]     ram_rdata;
  logic                       collision;

  survivor_mem_ctrl #(
    .N_ACS(N_ACS), .WD_RAM_DATA(WD_RAM_DATA), .WD_DEPTH(WD_DEPTH), .WD_SEG(WD_SEG)
  ) dut (
    .CLOCK(CLOCK), .Reset(Reset), .Active(Active), .Init(Init),
    .Survivors(Survivors), .surv_valid(surv_valid), .surv_ready(surv_ready),
    .acs_page(acs_page), .tb_req(tb_req), .tb_seg(tb_seg), .tb_ready(tb_ready),
    .tb_step(tb_step), .tb_page(tb_page), .tb_valid(tb_valid), .tb_data(tb_data),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .collision(collision)
  );

  always #5 CLOCK = ~CLOCK;

  // Behavioural RAM with one cycle of read latency.
  logic [WD_RAM_DATA-1:0] ramArray [WORDS];
  initial begin
    for (int i = 0; i < WORDS; i++) ramArray[i] = '0;
    ram_rdata = '0;
  end
  always @(posedge CLOCK) begin
    if (ram_en) begin
      if (ram_we) ramArray[ram_addr] <= ram_wdata;
      else        ram_rdata <= ramArray[ram_addr];
    end
  end

  int checkCount = 0;
  int errorCount = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, actual, expected);
    end
  endtask

  // Reference model state.
  typedef struct { int due; logic [WD_RAM_DATA-1:0] data; } read_t;
  logic [WD_RAM_DATA-1:0] refMem [WORDS];
  logic [WD_RAM_DATA-1:0] wordQ [$];
  read_t                  readQ [$];
  logic [WD_RAM_DATA-1:0] mPack;
  int  mLane;
  int  mWrIdx;
  int  mTbPage;
  bit  mLastWasWrite;
  bit  mColl;
  int  cyc;
  bit  lastRdGrant;

  initial for (int i = 0; i < WORDS; i++) refMem[i] = '0;

  task automatic modelReset();
    wordQ.delete();
    readQ.delete();
    mPack = '0;
    mLane = 0;
    mWrIdx = 0;
    mTbPage = 0;
    mLastWasWrite = 0;
    mColl = 0;
    lastRdGrant = 0;
  endtask

  // Compare every output against the model, then advance the model to
  // the state it will hold after the coming rising edge.
  task automatic checkCycle();
    bit expReady, expWr, expRd, cont, expValid;
    int acsP, rdAddr;
    read_t rd;
    acsP     = (mWrIdx / SEGS) % PAGES;
    expReady = Active && !(wordQ.size() > 0 && mLane == R - 1);
    cont     = (wordQ.size() > 0) && tb_req;
    expWr    = (wordQ.size() > 0) && (!tb_req || !mLastWasWrite);
    expRd    = tb_req && !expWr;
    rdAddr   = mTbPage * SEGS + int'(tb_seg);

    checkOutput("surv_ready", surv_ready, expReady);
    checkOutput("ram_en", ram_en, expWr || expRd);
    checkOutput("ram_we", ram_we, expWr);
    checkOutput("tb_ready", tb_ready, expRd);
    checkOutput("acs_page", acs_page, acsP);
    checkOutput("tb_page", tb_page, mTbPage);
    if (expWr) begin
      checkOutput("wr_addr", ram_addr, mWrIdx % WORDS);
      checkOutput("wr_data", ram_wdata, wordQ[0]);
    end else if (expRd) begin
      checkOutput("rd_addr", ram_addr, rdAddr);
    end else begin
      checkOutput("idle_addr", ram_addr, 0);
      checkOutput("idle_wdata", ram_wdata, 0);
    end
    expValid = (readQ.size() > 0) && (readQ[0].due == cyc);
    checkOutput("tb_valid", tb_valid, expValid);
    if (expValid) begin
      rd = readQ.pop_front();
      checkOutput("tb_data", tb_data, rd.data);
    end
    checkOutput("collision", collision, mColl);

    if (expRd) begin
      rd.due  = cyc + 2;
      rd.data = refMem[rdAddr];
      readQ.push_back(rd);
    end
    if (expWr) begin
      refMem[mWrIdx % WORDS] = wordQ.pop_front();
      mWrIdx++;
    end
    if (surv_valid && expReady) begin
      mPack[mLane*N_ACS +: N_ACS] = Survivors;
      mLane++;
      if (mLane == R) begin
        wordQ.push_back(mPack);
        mLane = 0;
      end
    end
    if (cont) mLastWasWrite = expWr;
`ifdef SMC_COLLISION_CHECK_EN
    if (Init) mColl = 0;
    else if (expRd && mTbPage == acsP) mColl = 1;
`endif
    if (Init) mTbPage = (acsP + PAGES - 1) % PAGES;
    else if (tb_step) mTbPage = (mTbPage + PAGES - 1) % PAGES;
    lastRdGrant = expRd;
    cyc++;
  endtask

  task automatic tick();
    @(negedge CLOCK);
    checkCycle();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic idleInputs();
    Active = 0; Init = 0; Survivors = '0; surv_valid = 0;
    tb_req = 0; tb_seg = '0; tb_step = 0;
  endtask

  task automatic doReset(input int cycles);
    Reset = 1;
    idleInputs();
    repeat (cycles) @(posedge CLOCK);
    #1;
    Reset = 0;
    modelReset();
  endtask

  // Random inputs for one cycle; a traceback request is held with its
  // segment until the model says it was granted.
  task automatic applyStimulus();
    Active     = ($urandom_range(15) != 0);
    surv_valid = ($urandom_range(3) != 0);
    Survivors  = N_ACS'($urandom);
    Init       = ($urandom_range(39) == 0);
    tb_step    = ($urandom_range(7) == 0);
    if (!(tb_req && !lastRdGrant)) begin
      tb_req = ($urandom_range(2) == 0);
      tb_seg = WD_SEG'($urandom);
    end
  endtask

  initial begin
    cyc = 0;
    modelReset();
    doReset(3);

    // Reset state, then the first packed word 0xA5 at address 0.
    checkOutput("rst_tb_data", tb_data, 0);
    Active = 1; surv_valid = 1; Survivors = 4'h5;
    tick();
    Survivors = 4'hA;
    tick();
    surv_valid = 0;
    @(negedge CLOCK);
    checkOutput("first_we", ram_we, 1);
    checkOutput("first_addr", ram_addr, 0);
    checkOutput("first_wdata", ram_wdata, 8'hA5);
    checkCycle();
    @(posedge CLOCK);
    #1;

    // Fill to 24 words so acs_page reaches 3, then Init and step back.
    for (int i = 0; i < 200 && mWrIdx < 24; i++) begin
      surv_valid = ((mWrIdx + wordQ.size()) * R + mLane < 24 * R);
      Survivors  = N_ACS'($urandom);
      tick();
    end
    surv_valid = 0;
    checkOutput("acs_page_3", acs_page, 3);
    Init = 1;
    tick();
    Init = 0;
    checkOutput("init_tb_page", tb_page, 2);
    tb_step = 1;
    repeat (3) tick();
    tb_step = 0;
    checkOutput("step_wrap", tb_page, 15);
    tick();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus();
      tick();
    end

    // Reset while a read is in flight; its data must never appear.
    for (int i = 0; i < 500 && !lastRdGrant; i++) begin
      applyStimulus();
      tick();
    end
    checkOutput("inflight_read", lastRdGrant, 1);
    doReset(1);
    tick();
    tick();
    checkOutput("post_rst_tb_data", tb_data, 0);

    for (int i = 0; i < 2500; i++) begin
      applyStimulus();
      tick();
    end

    // Drain outstanding work with no new traffic.
    idleInputs();
    repeat (6) tick();
    checkOutput("drained_reads", readQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/survivor_mem_ctrl.md
SURVIVOR_MEM_CTRL -- requirements
Module: survivor_mem_ctrl

Interface
REQ-001 SHALL have parameter N_ACS, default 4: survivor bits delivered per ACS beat.
REQ-002 SHALL have parameter WD_RAM_DATA, default 8: RAM word width; must be N_ACS*R, where R is a power of two and R>=1.
REQ-003 SHALL have parameter WD_DEPTH, default 4: page address bits; 2^WD_DEPTH pages.
REQ-004 SHALL have parameter WD_SEG, default 3: segment address bits; 2^WD_SEG words per page; RAM address width is WD_DEPTH+WD_SEG.
REQ-005 SHALL have port CLOCK  in  1: single clock, all state updates on rising edge.
REQ-006 SHALL have port Reset  in  1: synchronous, active-high.
REQ-007 SHALL have port Active  in  1: enables survivor acceptance.
REQ-008 SHALL have port Init  in  1: loads traceback page.
REQ-009 SHALL have port Survivors  in  N_ACS: ACS decisions.
REQ-010 SHALL have port surv_valid  in  1 and port surv_ready  out  1: survivor handshake.
REQ-011 SHALL have port acs_page  out  WD_DEPTH: current write page.
REQ-012 SHALL have port tb_req  in  1, port tb_seg  in  WD_SEG, and port tb_ready  out  1: traceback read request, its segment, and its grant.
REQ-013 SHALL have port tb_step  in  1: decrement traceback page.
REQ-014 SHALL have port tb_page  out  WD_DEPTH: current traceback page.
REQ-015 SHALL have port tb_valid  out  1 and port tb_data  out  WD_RAM_DATA: read return.
REQ-016 SHALL have ports ram_en, ram_we  out  1; ram_addr  out  WD_DEPTH+WD_SEG; ram_wdata  out  WD_RAM_DATA; ram_rdata  in  WD_RAM_DATA: single-port synchronous RAM with 1-cycle read latency.
REQ-017 SHALL have port collision  out  1: sticky page-collision flag.

Function
REQ-018 SHALL accept a beat when surv_valid && surv_ready; surv_ready = Active && !(wr_pend && lane==R-1).
REQ-019 SHALL pack accepted beats lane 0 first into the LSBs; lane counter 0..R-1; on acceptance at lane R-1, the packed word moves to the write holding register, wr_pend=1 and lane=0.
REQ-020 SHALL write the held word at {acs_page, wr_seg}; after each write wr_seg increments; on wr_seg wrap from 2^WD_SEG-1 to 0, acs_page increments modulo 2^WD_DEPTH.
REQ-021 SHALL grant at most one RAM access per cycle: write if only wr_pend; read if only tb_req; if both, grant the kind not granted at the last contention (first contention after reset: write).
REQ-022 SHALL on write grant drive ram_en=1, ram_we=1, ram_addr={acs_page,wr_seg}, ram_wdata=held word, and clear wr_pend at the edge.
REQ-023 SHALL on read grant in cycle G drive ram_en=1, ram_we=0, ram_addr={tb_page,tb_seg}, tb_ready=1 in G only; register ram_rdata in G+1; present tb_valid=1 and tb_data in G+2 for one cycle.
REQ-024 SHALL require tb_req and tb_seg held stable until tb_ready; back-to-back reads return in order, one per cycle.
REQ-025 SHALL drive ram_en=0 when no grant; ram_we, ram_addr and ram_wdata are don't-care with ram_en=0 but SHALL be driven to 0.
REQ-026 SHALL on Init load tb_page=acs_page-1 (mod 2^WD_DEPTH); else on tb_step tb_page decrements (wrap 0 to 2^WD_DEPTH-1); Init wins when both occur.
REQ-027 SHALL, when Active=0, complete pending writes and reads; the partial packer content is held, not discarded.
REQ-028 SHALL use the acs_page value before the increment when a write grant and Init coincide.

Reset
REQ-029 SHALL on Reset clear lane, wr_pend, wr_seg, acs_page, tb_page, the arbitration history, tb_valid, tb_data, collision, and the read pipeline; all outputs 0 in the cycle after Reset.
REQ-030 SHALL drop in-flight reads on Reset mid-operation, with no tb_valid after Reset.

Configuration
REQ-031 SHALL, with SMC_COLLISION_CHECK_EN defined, set collision at any read grant where tb_page==acs_page; collision clears only on Reset or Init.
REQ-032 SHALL, without SMC_COLLISION_CHECK_EN, tie collision to 0 and add no comparator logic.

Verification
REQ-033 Default params, Survivors 0x5 then 0xA accepted -> one write, ram_addr=0x00, ram_wdata=0xA5, wr_seg=1.
REQ-034 Write 8 words -> acs_page 0 to 1 on the 8th write; 128 words -> acs_page wraps to 0.
REQ-035 acs_page=3, Init -> tb_page=2; tb_step x3 -> tb_page=15.
REQ-036 wr_pend and tb_req together in 4 consecutive contentions -> grants W,R,W,R; tb_valid exactly 2 cycles after each tb_ready.
REQ-037 wr_pend=1, lane=1, surv_valid=1 -> surv_ready=0 until the write grant, then the beat is accepted.
REQ-038 SMC_COLLISION_CHECK_EN defined, read with tb_page==acs_page=5 -> collision=1, held until Init; undefined -> collision stays 0.
